// File: rtl/bram_stream_reader.sv
// Streams LENGTH words from a 1-cycle-latency block RAM, starting at BASE_ADDR and wrapping
// around the address space, onto a valid/ready stream through a 2-entry skid FIFO.
module bram_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     remain_q, remain_d;
  logic                    done_q, done_d;
  logic                    inflight_q, inflight_last_q;
  logic [DATA_WIDTH-1:0]   fifo_data_q [2];
  logic                    fifo_last_q [2];
  logic                    wr_ptr_q, rd_ptr_q;
  logic [1:0]              count_q, count_d;
  logic                    rd_en, last_issue, push, pop, credit_ok;

  assign m_valid = (count_q != 2'd0);
  assign m_data  = fifo_data_q[rd_ptr_q];
  assign m_last  = m_valid & fifo_last_q[rd_ptr_q];
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign r_addr  = addr_q;

  assign push = inflight_q;
  assign pop  = m_valid & m_ready;
  // A new read may only be issued if its word is guaranteed a FIFO slot when it lands.
  assign credit_ok = ({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    done_d     = 1'b0;
    rd_en      = 1'b0;
    last_issue = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = S_RUN;
            addr_d   = base_addr;
            remain_d = (length > MAX_LEN) ? MAX_LEN : length;
          end
        end
      end
      S_RUN: begin
        if (credit_ok) begin
          rd_en    = 1'b1;
          addr_d   = addr_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (remain_q == (ADDR_WIDTH+1)'(1)) begin
            last_issue = 1'b1;
            state_d    = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pop && fifo_last_q[rd_ptr_q]) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      remain_q        <= '0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remain_q        <= remain_d;
      done_q          <= done_d;
      inflight_q      <= rd_en;
      inflight_last_q <= last_issue;
      count_q         <= count_d;
      if (push) begin
        fifo_data_q[wr_ptr_q] <= r_data;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: behavioural BRAM, transfer-level scoreboard and cycle model
// of busy/done/latency, with stimulus driven 1ns after each rising edge.
module tb_bram_stream_reader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [1:0] base_addr;
  logic [2:0] length;
  logic       busy, done;
  logic [1:0] r_addr;
  logic [7:0] r_data;
  logic [7:0] m_data;
  logic       m_valid, m_ready, m_last;

  logic       we;
  logic [1:0] wa;
  logic [7:0] wd;
  logic [7:0] mem [4];

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;
  beat_t exp_q [$];

  logic mdl_busy = 1'b0;
  logic exp_done = 1'b0;
  int   lat_cnt  = 0;
  int   beat_cnt = 0;
  logic stall_prev = 1'b0;
  logic [7:0] stall_data;
  logic stall_last;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we) mem[wa] <= wd;
    r_data <= mem[r_addr];
  end

  bram_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .r_addr(r_addr), .r_data(r_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model and scoreboard, evaluated on the falling edge.
  always @(negedge clk) begin
    logic nb, nd;
    int   len;
    beat_t e;
    if (!reset_n) begin
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", m_valid, 0);
      check("rst_last", m_last, 0);
      check("rst_data", m_data, 0);
      check("rst_raddr", r_addr, 0);
      exp_q.delete();
      mdl_busy   = 1'b0;
      exp_done   = 1'b0;
      lat_cnt    = 0;
      stall_prev = 1'b0;
    end else begin
      check("done", done, exp_done);
      check("busy", busy, mdl_busy);
      if (!mdl_busy) check("idle_valid", m_valid, 0);
      if (lat_cnt != 0) check("latency_valid", m_valid, (lat_cnt == 3) ? 1 : 0);
      if (stall_prev) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, stall_data);
        check("stall_last", m_last, stall_last);
      end
      nb = mdl_busy;
      nd = 1'b0;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", m_data, e.data);
          check("beat_last", m_last, e.last);
          $display("beat %0d data=%h last=%0d", beat_cnt, m_data, m_last);
          beat_cnt++;
          if (e.last) begin
            nb = 1'b0;
            nd = 1'b1;
          end
        end
      end
      lat_cnt = (lat_cnt != 0 && lat_cnt < 3) ? lat_cnt + 1 : 0;
      if (!mdl_busy && start) begin
        len = (length > 3'd4) ? 4 : int'(length);
        if (len == 0) begin
          nd = 1'b1;
        end else begin
          nb = 1'b1;
          lat_cnt = 1;
          for (int k = 0; k < len; k++) begin
            e.data = 8'hA0 + 8'((int'(base_addr) + k) % 4);
            e.last = (k == len - 1);
            exp_q.push_back(e);
          end
        end
      end
      stall_prev = m_valid && !m_ready;
      stall_data = m_data;
      stall_last = m_last;
      mdl_busy   = nb;
      exp_done   = nd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic [1:0] b, input logic [2:0] l);
    start = 1'b1;
    base_addr = b;
    length = l;
    tick();
    start = 1'b0;
  endtask

  // mode 0: always ready, 1: pattern 1,0,0,1,0,1, 2: random
  task automatic wait_idle(input int mode);
    for (int i = 0; i < 200; i++) begin
      if (!mdl_busy && exp_q.size() == 0) break;
      case (mode)
        1: m_ready = ((i % 6) == 0) || ((i % 6) == 3) || ((i % 6) == 5);
        2: m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
      tick();
    end
    m_ready = 1'b1;
    check("drained_q", exp_q.size(), 0);
    check("drained_busy", mdl_busy, 0);
  endtask

  initial begin
    int b0;
    reset_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    m_ready = 1'b1;
    we = 1'b0;
    wa = '0;
    wd = '0;
    tick();
    for (int i = 0; i < 4; i++) begin
      we = 1'b1;
      wa = 2'(i);
      wd = 8'hA0 + 8'(i);
      tick();
    end
    we = 1'b0;
    reset_n = 1'b1;
    tick();
    tick();

    // 1: full sweep, always ready
    start_xfer(2'd0, 3'd4);
    wait_idle(0);
    tick();

    // 2: wrap-around with address sequence 3,0,1
    start_xfer(2'd3, 3'd3);
    check("raddr0", r_addr, 3);
    tick();
    check("raddr1", r_addr, 0);
    tick();
    check("raddr2", r_addr, 1);
    wait_idle(0);
    tick();

    // 3: backpressure pattern
    start_xfer(2'd0, 3'd4);
    wait_idle(1);
    tick();

    // 4: zero length, then oversize length clamped to 4
    start_xfer(2'd2, 3'd0);
    wait_idle(0);
    tick();
    tick();
    start_xfer(2'd1, 3'd7);
    wait_idle(0);
    tick();

    // 5: async reset after the second beat, then a fresh transfer
    b0 = beat_cnt;
    start_xfer(2'd0, 3'd4);
    for (int i = 0; i < 50 && beat_cnt < b0 + 2; i++) tick();
    check("beats_before_reset", beat_cnt - b0, 2);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    start_xfer(2'd1, 3'd2);
    wait_idle(0);
    tick();

    // 6: start while busy is ignored; back-to-back start in the done cycle
    start_xfer(2'd2, 3'd3);
    start = 1'b1;
    base_addr = 2'd0;
    length = 3'd1;
    tick();
    tick();
    start = 1'b0;
    for (int i = 0; i < 50 && !exp_done; i++) tick();
    check("done_seen", exp_done, 1);
    start_xfer(2'd3, 3'd4);
    wait_idle(2);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
